ycbcr2rgb: RTL and testbench



---
 rtl/ycbcr2rgb.sv | 141 ++++++++++++++
 tb/tb_ycbcr2rgb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ycbcr2rgb.sv
// Full-range BT.601 YCbCr 4:4:4 to RGB888 converter, 3-stage pipeline with delay-matched timing.
// Define YCBCR2RGB_OUT_REG_EN to add one output register stage (latency 4 instead of 3).
module ycbcr2rgb #(
    parameter int C_RV = 359,
    parameter int C_GU = 88,
    parameter int C_GV = 183,
    parameter int C_BU = 454
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [23:0] pixel_in,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [23:0] pixel_out
);

    // Worst-case sum is 65280 + 58112 + 128, so 20 signed bits never overflow.
    localparam int W = 20;
    typedef logic signed [W-1:0] acc_t;

    localparam acc_t K_RV = acc_t'(C_RV);
    localparam acc_t K_GU = acc_t'(C_GU);
    localparam acc_t K_GV = acc_t'(C_GV);
    localparam acc_t K_BU = acc_t'(C_BU);
    localparam acc_t K_RND = acc_t'(128);

    function automatic acc_t sext9(input logic signed [8:0] x);
        sext9 = {{(W-9){x[8]}}, x};
    endfunction

    // Floor-divide by 256, then saturate into 0..255.
    function automatic logic [7:0] clamp8(input acc_t s);
        acc_t q;
        q = s >>> 8;
        if (q[W-1]) begin
            clamp8 = 8'h00;
        end else if (|q[W-2:8]) begin
            clamp8 = 8'hff;
        end else begin
            clamp8 = q[7:0];
        end
    endfunction

    logic signed [8:0] y_r, u_r, v_r;
    logic        [2:0] sync1_r, sync2_r, sync3_r;
    acc_t              ys_r, pr_r, pg_r, pb_r;
    acc_t              ys_s, pr_s, pg_s, pb_s;
    acc_t              sum_r_s, sum_g_s, sum_b_s;
    logic       [23:0] rgb_s;
    logic       [23:0] pix3_r;

    // Stage 1: remove chroma offset, capture timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r     <= '0;
            u_r     <= '0;
            v_r     <= '0;
            sync1_r <= 3'b000;
        end else begin
            y_r     <= {1'b0, pixel_in[23:16]};
            u_r     <= {1'b0, pixel_in[15:8]} - 9'd128;
            v_r     <= {1'b0, pixel_in[7:0]} - 9'd128;
            sync1_r <= {de_in, hsync_in, vsync_in};
        end
    end

    // Stage 2 products in Q8.
    always_comb begin
        ys_s = sext9(y_r) <<< 8;
        pr_s = K_RV * sext9(v_r);
        pg_s = K_GU * sext9(u_r) + K_GV * sext9(v_r);
        pb_s = K_BU * sext9(u_r);
    end

    // Stage 2: register products and timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ys_r    <= '0;
            pr_r    <= '0;
            pg_r    <= '0;
            pb_r    <= '0;
            sync2_r <= 3'b000;
        end else begin
            ys_r    <= ys_s;
            pr_r    <= pr_s;
            pg_r    <= pg_s;
            pb_r    <= pb_s;
            sync2_r <= sync1_r;
        end
    end

    // Stage 3 rounding sums and clamp.
    always_comb begin
        sum_r_s = ys_r + pr_r + K_RND;
        sum_g_s = ys_r - pg_r + K_RND;
        sum_b_s = ys_r + pb_r + K_RND;
        rgb_s   = {clamp8(sum_r_s), clamp8(sum_g_s), clamp8(sum_b_s)};
    end

    // Stage 3: register result, blanked outside active video.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix3_r  <= 24'h000000;
            sync3_r <= 3'b000;
        end else begin
            pix3_r  <= sync2_r[2] ? rgb_s : 24'h000000;
            sync3_r <= sync2_r;
        end
    end

`ifdef YCBCR2RGB_OUT_REG_EN
    logic [23:0] pix4_r;
    logic  [2:0] sync4_r;

    // Extra output stage; blanking already applied upstream with the matching de.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix4_r  <= 24'h000000;
            sync4_r <= 3'b000;
        end else begin
            pix4_r  <= pix3_r;
            sync4_r <= sync3_r;
        end
    end

    assign pixel_out = pix4_r;
    assign de_out    = sync4_r[2];
    assign hsync_out = sync4_r[1];
    assign vsync_out = sync4_r[0];
`else
    assign pixel_out = pix3_r;
    assign de_out    = sync3_r[2];
    assign hsync_out = sync3_r[1];
    assign vsync_out = sync3_r[0];
`endif

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Self-checking bench for ycbcr2rgb: arithmetic reference model plus directed literal vectors.
// Latency follows YCBCR2RGB_OUT_REG_EN like the design.
module tb_ycbcr2rgb;

`ifdef YCBCR2RGB_OUT_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        rst_n;
    logic        de_in, hsync_in, vsync_in;
    logic [23:0] pixel_in;
    logic        de_out, hsync_out, vsync_out;
    logic [23:0] pixel_out;

    int n_run  = 0;
    int n_fail = 0;
    bit done   = 1'b0;

    logic [26:0] pipe [LAT];
    logic [26:0] exp_cur;
    logic [23:0] lfsr;

    ycbcr2rgb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .de_in     (de_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .pixel_in  (pixel_in),
        .de_out    (de_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .pixel_out (pixel_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] sat(input int x);
        if (x < 0) return 8'd0;
        else if (x > 255) return 8'd255;
        else return 8'(x);
    endfunction

    // Plain integer BT.601 inverse with round-half-up and floor shift.
    function automatic logic [23:0] ref_px(input logic [23:0] p);
        int y, u, v, r, g, b;
        y = int'(p[23:16]);
        u = int'(p[15:8]) - 128;
        v = int'(p[7:0]) - 128;
        r = (y * 256 + 359 * v + 128) >>> 8;
        g = (y * 256 - 88 * u - 183 * v + 128) >>> 8;
        b = (y * 256 + 454 * u + 128) >>> 8;
        return {sat(r), sat(g), sat(b)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_run++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Reference: expected output is the model of the input seen LAT-1 edges earlier; reset empties it.
    initial begin
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        exp_cur = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < LAT; i++) pipe[i] = '0;
                exp_cur = '0;
            end else begin
                for (int i = 0; i < LAT - 1; i++) pipe[i] = pipe[i+1];
                pipe[LAT-1] = {de_in, hsync_in, vsync_in,
                               de_in ? ref_px(pixel_in) : 24'h000000};
                exp_cur = pipe[0];
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                chk("stream", {5'd0, de_out, hsync_out, vsync_out, pixel_out}, {5'd0, exp_cur});
                if (de_out === 1'b0) chk("blank", {8'd0, pixel_out}, 32'd0);
            end
        end
    end

    task automatic drive(input logic de, input logic hs, input logic vs, input logic [23:0] p);
        @(posedge clk);
        #2;
        de_in    = de;
        hsync_in = hs;
        vsync_in = vs;
        pixel_in = p;
    endtask

    task automatic vec(input string name, input logic [23:0] p, input logic [23:0] want);
        drive(1'b1, 1'b0, 1'b0, p);
        repeat (LAT) @(posedge clk);
        #1;
        chk(name, {8'd0, pixel_out}, {8'd0, want});
    endtask

    function automatic logic [23:0] lfsr_next(input logic [23:0] s);
        return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
    endfunction

    initial begin
        rst_n = 1'b0;
        de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; pixel_in = 24'h000000;
        lfsr = 24'h000001;

        // Reset held with toggling inputs: all outputs stay zero.
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom));
            @(posedge clk);
            #1;
            chk("rst_hold", {5'd0, de_out, hsync_out, vsync_out, pixel_out}, 32'd0);
        end

        // Release with constant grey.
        @(posedge clk);
        #2;
        rst_n = 1'b1; de_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; pixel_in = 24'h808080;
        for (int k = 1; k < LAT; k++) begin
            @(posedge clk);
            #1;
            chk("rst_lat_zero", {8'd0, pixel_out}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("rst_lat_grey", {8'd0, pixel_out}, 32'h00808080);

        // Literal vectors pinning the model.
        vec("roundtrip", 24'h4ee146, 24'h0056fa);
        vec("sat_r_hi",  24'hff80ff, 24'hffa4ff);
        vec("sat_white", 24'hff8080, 24'hffffff);
        vec("black",     24'h008080, 24'h000000);

        // 64 back-to-back LFSR pixels.
        for (int i = 0; i < 64; i++) begin
            lfsr = lfsr_next(lfsr);
            drive(1'b1, 1'b0, 1'b0, lfsr);
        end

        // A short line: hsync pulse, de gap, vsync edge mid-line.
        for (int i = 0; i < 16; i++) begin
            lfsr = lfsr_next(lfsr);
            drive((i >= 2 && i <= 5) || (i >= 7 && i <= 12), i < 2, i >= 8, lfsr);
        end

        // Streaming, then an asynchronous reset between edges.
        for (int i = 0; i < 8; i++) begin
            lfsr = lfsr_next(lfsr);
            drive(1'b1, i[0], 1'b0, lfsr);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {5'd0, de_out, hsync_out, vsync_out, pixel_out}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            lfsr = lfsr_next(lfsr);
            drive(1'b1, 1'b1, 1'b1, lfsr);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            lfsr = lfsr_next(lfsr);
            drive(1'b1, 1'b0, i[1], lfsr);
        end

        // Flush with blanking.
        for (int i = 0; i < LAT + 2; i++) drive(1'b0, 1'b0, 1'b0, 24'h123456);
        @(negedge clk);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
